// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and helpers for the UART receive frame controller.
// Counter widths cover the full legal range of OVERSAMPLE (8..32) and DATA_WIDTH (5..9).
package uart_rx_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_e;

    localparam int MAX_DATA_WIDTH = 9;
    localparam int MAX_OVERSAMPLE = 32;
    localparam int SMP_CNT_W      = $clog2(MAX_OVERSAMPLE);
    localparam int BIT_CNT_W      = $clog2(MAX_DATA_WIDTH + 1);

    function automatic logic parity_calc(input logic [MAX_DATA_WIDTH-1:0] data,
                                         input logic                      odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Oversample tick generator: one-clk tick every (baud_div+1) clks while enabled.
// baud_div is captured while disabled; the counter holds at reload until enabled.
module uart_baud_tick_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] baud_div,
    output logic        tick
);

    logic [15:0] cnt;
    logic [15:0] div_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            div_q <= '0;
        end else if (!en) begin
            cnt   <= baud_div;
            div_q <= baud_div;
        end else if (cnt == 16'd0) begin
            cnt <= div_q;
        end else begin
            cnt <= cnt - 16'd1;
        end
    end

    assign tick = en && (cnt == 16'd0);

endmodule

// File: rtl/uart_rx_frame_controller.sv
// UART frame receiver: start qualification, mid-bit sampling, parity/stop checks.
// frame_valid rises 2 clk after the last stop sample edge; one-entry buffer, overrun if full.
module uart_rx_frame_controller
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           baud_div,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] frame_data,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  parity_err,
    output logic                  framing_err,
    output logic                  overrun,
    input  logic                  overrun_clr,
    output logic                  busy
);

    localparam logic [SMP_CNT_W-1:0] MID_CNT   = SMP_CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SMP_CNT_W-1:0] BIT_END   = SMP_CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

    rx_state_e state, next_state;

    logic                  rx_meta, rx_sync, rx_prev;
    logic                  rx_fall;
    logic                  tick, tick_en;
    logic                  sample_pt;
    logic [SMP_CNT_W-1:0]  smp_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_bad, frm_bad;
    logic                  load;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev && !rx_sync;

    uart_baud_tick_gen u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .en       (tick_en),
        .baud_div (baud_div),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:   if (rx_fall) next_state = START;
            START:  if (sample_pt) next_state = rx_sync ? IDLE : DATA;
            DATA:   if (sample_pt && bit_cnt == LAST_DATA)
                        next_state = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY: if (sample_pt) next_state = STOP;
            STOP:   if (sample_pt && bit_cnt == LAST_STOP) next_state = DONE;
            DONE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        tick_en   = (state != IDLE);
        sample_pt = 1'b0;
        unique case (state)
            START:              sample_pt = tick && (smp_cnt == MID_CNT);
            DATA, PARITY, STOP: sample_pt = tick && (smp_cnt == BIT_END);
            default:            sample_pt = 1'b0;
        endcase
    end

    // STOP reuses bit_cnt to count stop bits; it is zero on leaving DATA.
    always_ff @(posedge clk) begin
        if (reset) begin
            smp_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bad   <= 1'b0;
            frm_bad   <= 1'b0;
        end else if (state == IDLE) begin
            smp_cnt <= '0;
            bit_cnt <= '0;
            par_bad <= 1'b0;
            frm_bad <= 1'b0;
        end else begin
            if (tick) begin
                smp_cnt <= sample_pt ? '0 : smp_cnt + 1'b1;
            end
            if (sample_pt) begin
                unique case (state)
                    DATA: begin
                        shift_reg <= {rx_sync, shift_reg[DATA_WIDTH-1:1]};
                        bit_cnt   <= (bit_cnt == LAST_DATA) ? '0 : bit_cnt + 1'b1;
                    end
                    PARITY: begin
                        par_bad <= (rx_sync != parity_calc(MAX_DATA_WIDTH'(shift_reg),
                                                           1'(PARITY_ODD)));
                    end
                    STOP: begin
                        if (!rx_sync) frm_bad <= 1'b1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign load = (state == DONE) && (!frame_valid || frame_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_data  <= '0;
            frame_valid <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (load) begin
                frame_data  <= shift_reg;
                parity_err  <= par_bad;
                framing_err <= frm_bad;
                frame_valid <= 1'b1;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
            if ((state == DONE) && frame_valid && !frame_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
